// File: rtl/counting_bloom_filter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// counting_bloom_filter_if : request/response bus   (rev 1.0)
// ------------------------------------------------------------------
interface counting_bloom_filter_if #(
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [DATA_W-1:0] req_data;
   logic              resp_valid;
   logic              resp_hit;
   logic              resp_err;
   logic [15:0]       elem_count;

   modport master (
      output req_valid, req_op, req_data,
      input  req_ready, resp_valid, resp_hit, resp_err, elem_count
   );

   modport slave (
      input  req_valid, req_op, req_data,
      output req_ready, resp_valid, resp_hit, resp_err, elem_count
   );
endinterface
`default_nettype wire

// File: rtl/counting_bloom_filter.sv
`default_nettype none
// ------------------------------------------------------------------
// counting_bloom_filter : K-hash counting Bloom filter with
// saturating buckets, safe delete and sequenced clear   (rev 1.0)
// ------------------------------------------------------------------
module counting_bloom_filter #(
   parameter int          DATA_W = 32,
   parameter int          M      = 256,
   parameter int          K      = 3,
   parameter int          CNT_W  = 4,
   parameter logic [31:0] SEED   = 32'h9E3779B9
) (
   input logic                    clk,
   input logic                    rst,
   counting_bloom_filter_if.slave bus
);
   localparam int IDX_W  = $clog2(M);
   localparam int NSLICE = (DATA_W + IDX_W - 1) / IDX_W;
   localparam int PAD_W  = NSLICE * IDX_W;
   localparam logic [CNT_W-1:0] CMAX   = '1;
   localparam logic [IDX_W-1:0] LAST_K = IDX_W'(K - 1);
   localparam logic [IDX_W-1:0] LAST_M = IDX_W'(M - 1);
   localparam logic [1:0] c_OP_QUERY  = 2'd0;
   localparam logic [1:0] c_OP_INSERT = 2'd1;
   localparam logic [1:0] c_OP_DELETE = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_CHK  = 3'd2,
      S_DEC  = 3'd3,
      S_CLR  = 3'd4,
      S_RESP = 3'd5
   } state_t;

   state_t            r_state;
   logic [1:0]        r_op;
   logic [DATA_W-1:0] r_key;
   logic [IDX_W-1:0]  r_step;
   logic              r_hit;
   logic              r_err;
   logic              r_ready;
   logic              r_resp_valid;
   logic              r_resp_hit;
   logic              r_resp_err;
   logic [15:0]       r_elem_count;
   logic [CNT_W-1:0]  r_cnt [M];

   logic [IDX_W-1:0]  w_idx [K];
   logic [IDX_W-1:0]  w_cur_idx;
   logic [CNT_W-1:0]  w_cur_cnt;
   logic              w_hit_acc;
   logic              w_last_k;
   logic              w_cur_sat;

   for (genvar gi = 0; gi < K; gi++) begin : g_hash
      localparam int ROT = (8 * gi) % DATA_W;
      localparam logic [DATA_W-1:0] MIX = DATA_W'(SEED) * DATA_W'(gi + 1);
      logic [DATA_W-1:0] w_rot;
      logic [PAD_W-1:0]  w_pad;
      logic [IDX_W-1:0]  w_fold;

      if (ROT == 0) begin : g_norot
         assign w_rot = r_key;
      end else begin : g_rot
         assign w_rot = {r_key[DATA_W-1-ROT:0], r_key[DATA_W-1:DATA_W-ROT]};
      end

      // Top slice is zero-padded when IDX_W does not divide DATA_W.
      assign w_pad = PAD_W'(w_rot ^ MIX);

      always_comb begin
         w_fold = '0;
         for (int s = 0; s < NSLICE; s++) begin
            w_fold = w_fold ^ w_pad[s*IDX_W +: IDX_W];
         end
      end

      assign w_idx[gi] = w_fold;
   end

   always_comb begin
      w_cur_idx = '0;
      for (int i = 0; i < K; i++) begin
         if (r_step == IDX_W'(i)) begin
            w_cur_idx = w_idx[i];
         end
      end
   end

   assign w_cur_cnt = r_cnt[w_cur_idx];
   assign w_cur_sat = (w_cur_cnt == CMAX);
   assign w_hit_acc = r_hit & (w_cur_cnt != '0);
   assign w_last_k  = (r_step == LAST_K);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_op         <= c_OP_QUERY;
         r_key        <= '0;
         r_step       <= '0;
         r_hit        <= 1'b0;
         r_err        <= 1'b0;
         r_ready      <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_hit   <= 1'b0;
         r_resp_err   <= 1'b0;
         r_elem_count <= '0;
         for (int j = 0; j < M; j++) begin
            r_cnt[j] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_op    <= bus.req_op;
                  r_key   <= bus.req_data;
                  r_step  <= '0;
                  r_hit   <= 1'b1;
                  r_err   <= 1'b0;
                  r_ready <= 1'b0;
                  case (bus.req_op)
                     c_OP_QUERY, c_OP_INSERT: r_state <= S_RUN;
                     c_OP_DELETE:             r_state <= S_CHK;
                     default:                 r_state <= S_CLR;
                  endcase
               end
            end
            S_RUN: begin
               r_hit <= w_hit_acc;
               if (r_op == c_OP_INSERT) begin
                  if (w_cur_sat) r_err <= 1'b1;
                  else           r_cnt[w_cur_idx] <= w_cur_cnt + CNT_W'(1);
               end
               if (w_last_k) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_hit   <= (r_op == c_OP_QUERY) & w_hit_acc;
                  r_resp_err   <= (r_op == c_OP_INSERT) & (r_err | w_cur_sat);
                  if (r_op == c_OP_INSERT && r_elem_count != 16'hFFFF) begin
                     r_elem_count <= r_elem_count + 16'd1;
                  end
               end else begin
                  r_step <= r_step + IDX_W'(1);
               end
            end
            S_CHK: begin
               r_hit <= w_hit_acc;
               if (w_last_k) begin
                  r_step <= '0;
                  if (w_hit_acc) begin
                     r_state <= S_DEC;
                  end else begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_hit   <= 1'b0;
                     r_resp_err   <= 1'b1;
                  end
               end else begin
                  r_step <= r_step + IDX_W'(1);
               end
            end
            S_DEC: begin
               // A bucket at CMAX has lost its true count, so it stays pinned.
               if (w_cur_cnt == '0)  r_err <= 1'b1;
               else if (!w_cur_sat)  r_cnt[w_cur_idx] <= w_cur_cnt - CNT_W'(1);
               if (w_last_k) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_hit   <= 1'b1;
                  r_resp_err   <= r_err | (w_cur_cnt == '0);
                  if (r_elem_count != 16'd0) begin
                     r_elem_count <= r_elem_count - 16'd1;
                  end
               end else begin
                  r_step <= r_step + IDX_W'(1);
               end
            end
            S_CLR: begin
               r_cnt[r_step] <= '0;
               if (r_step == LAST_M) begin
                  r_state      <= S_RESP;
                  r_elem_count <= '0;
                  r_resp_valid <= 1'b1;
                  r_resp_hit   <= 1'b0;
                  r_resp_err   <= 1'b0;
               end else begin
                  r_step <= r_step + IDX_W'(1);
               end
            end
            S_RESP: begin
               r_resp_valid <= 1'b0;
               r_resp_hit   <= 1'b0;
               r_resp_err   <= 1'b0;
               r_ready      <= 1'b1;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = r_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_hit   = r_resp_hit;
   assign bus.resp_err   = r_resp_err;
   assign bus.elem_count = r_elem_count;
endmodule
`default_nettype wire

// File: tb/tb_counting_bloom_filter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_counting_bloom_filter : scoreboard bench for counting_bloom_filter
// ------------------------------------------------------------------
module tb_counting_bloom_filter;
   localparam int          K    = 3;
   localparam int          M    = 256;
   localparam logic [31:0] SEED = 32'h9E3779B9;
   localparam logic [1:0]  OP_Q = 2'd0, OP_I = 2'd1, OP_D = 2'd2, OP_C = 2'd3;

   typedef struct {
      logic hit;
      logic err;
      int   cnt;
      int   lat;
      int   acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   int   mcnt[M];
   int   mcount = 0;
   int   last_resp = -100;
   bit   pend = 1'b0;
   int   pend_cnt = 0;

   counting_bloom_filter_if #(.DATA_W(32)) bus ();

   counting_bloom_filter #(
      .DATA_W(32), .M(M), .K(K), .CNT_W(4), .SEED(SEED)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int hidx(input logic [31:0] d, input int i);
      logic [31:0] x;
      logic [63:0] p;
      int r;
      r = (8 * i) % 32;
      for (int b = 0; b < 32; b++) x[(b + r) % 32] = d[b];
      p = 64'(SEED) * 64'(i + 1);
      x = x ^ p[31:0];
      return int'(x[7:0] ^ x[15:8] ^ x[23:16] ^ x[31:24]);
   endfunction

   task automatic model(input logic [1:0] op, input logic [31:0] d, output exp_t e);
      int j;
      bit ok;
      e.hit = 1'b0; e.err = 1'b0; e.lat = K + 1; e.acc = 0;
      case (op)
         OP_Q: begin
            e.hit = 1'b1;
            for (int i = 0; i < K; i++) if (mcnt[hidx(d, i)] == 0) e.hit = 1'b0;
         end
         OP_I: begin
            for (int i = 0; i < K; i++) begin
               j = hidx(d, i);
               if (mcnt[j] == 15) e.err = 1'b1;
               else mcnt[j]++;
            end
            if (mcount < 65535) mcount++;
         end
         OP_D: begin
            ok = 1'b1;
            for (int i = 0; i < K; i++) if (mcnt[hidx(d, i)] == 0) ok = 1'b0;
            if (!ok) begin
               e.err = 1'b1;
            end else begin
               e.hit = 1'b1;
               e.lat = 2 * K + 1;
               for (int i = 0; i < K; i++) begin
                  j = hidx(d, i);
                  if (mcnt[j] == 0) e.err = 1'b1;
                  else if (mcnt[j] != 15) mcnt[j]--;
               end
               if (mcount > 0) mcount--;
            end
         end
         default: begin
            for (int i = 0; i < M; i++) mcnt[i] = 0;
            mcount = 0;
            e.lat = M + 1;
         end
      endcase
      e.cnt = mcount;
   endtask

   // Waits for req_ready, accepts at the next edge and records the expectation.
   task automatic send(input logic [1:0] op, input logic [31:0] d, input bit hold);
      exp_t e;
      int n;
      n = 0;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_data  = d;
      while (!bus.req_ready && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 2000) begin
         checks++; failures++;
         $display("FAIL accept_timeout: got req_ready=0 expected 1 within 2000 cycles");
         bus.req_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         model(op, d, e);
         e.acc = cyc;
         sb.push_back(e);
         if (!hold) bus.req_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || pend) && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 5000) begin
         checks++; failures++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      bus.req_valid = 1'b0;
      sb.delete();
      pend = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      for (int i = 0; i < M; i++) mcnt[i] = 0;
      mcount = 0;
      @(posedge clk); #1;
      check("rst_ready", bus.req_ready, 1);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_resp_hit", bus.resp_hit, 0);
      check("rst_resp_err", bus.resp_err, 0);
      check("rst_elem_count", bus.elem_count, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (pend) begin
            pend = 1'b0;
            check("elem_count", bus.elem_count, pend_cnt);
            check("ready_after_resp", bus.req_ready, 1);
         end
         if (bus.resp_valid) begin
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               check("resp_hit", bus.resp_hit, e.hit);
               check("resp_err", bus.resp_err, e.err);
               check("resp_latency", cyc - e.acc + 1, e.lat);
               pend      = 1'b1;
               pend_cnt  = e.cnt;
               last_resp = cyc;
            end
         end else begin
            check("idle_hit_err", {bus.resp_hit, bus.resp_err}, 0);
         end
      end
   end

   initial begin : stimulus
      int n;
      logic [1:0] op;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'd0;
      bus.req_data  = '0;
      for (int i = 0; i < M; i++) mcnt[i] = 0;
      do_reset(3);

      // Insert then query the same key and a neighbour.
      send(OP_I, 32'hc0a9011e, 0);
      drain();
      check("c1_elem_count", bus.elem_count, 1);
      send(OP_Q, 32'hc0a9011e, 0);
      send(OP_Q, 32'hc0a90128, 0);
      drain();

      // Delete, re-query, and a rejected delete on an empty filter.
      send(OP_D, 32'hc0a9011e, 0);
      drain();
      check("c2_elem_count", bus.elem_count, 0);
      send(OP_Q, 32'hc0a9011e, 0);
      send(OP_D, 32'h12345678, 0);
      send(OP_Q, 32'h12345678, 0);
      drain();

      // Saturation and sticky buckets.
      for (int i = 0; i < 20; i++) send(OP_I, 32'hc0a8011e, 0);
      drain();
      check("c3_elem_count_full", bus.elem_count, 20);
      send(OP_Q, 32'hc0a8011e, 0);
      for (int i = 0; i < 20; i++) send(OP_D, 32'hc0a8011e, 0);
      send(OP_Q, 32'hc0a8011e, 0);
      drain();
      check("c3_elem_count_empty", bus.elem_count, 0);

      // Clear after five inserts.
      for (int i = 0; i < 5; i++) send(OP_I, 32'h0a000001 + 32'(i * 7), 0);
      drain();
      send(OP_C, 32'h0, 0);
      n = 0;
      while (!bus.req_ready && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check("c4_ready_low_cycles", n, 257);
      drain();
      check("c4_elem_count", bus.elem_count, 0);
      for (int i = 0; i < 5; i++) send(OP_Q, 32'h0a000001 + 32'(i * 7), 0);
      drain();

      // Held req_valid, alternating INSERT/QUERY.
      for (int i = 0; i < 8; i++) begin
         op = (i % 2 == 0) ? OP_I : OP_Q;
         send(op, 32'hA0000000 + 32'(i / 2), i != 7);
         if (i > 0) check("b2b_gap", cyc - last_resp, 2);
      end
      drain();

      // Reset during DEC of a DELETE.
      send(OP_I, 32'h55aa1234, 0);
      drain();
      send(OP_D, 32'h55aa1234, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
      end
      do_reset(2);
      send(OP_Q, 32'h55aa1234, 0);
      drain();

      // Reset during CLR cycle 100.
      send(OP_I, 32'h55aa1234, 0);
      drain();
      send(OP_C, 32'h0, 0);
      for (int i = 0; i < 99; i++) begin
         @(posedge clk); #1;
      end
      do_reset(2);
      send(OP_Q, 32'h55aa1234, 0);
      drain();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
